// File: rtl/attack_controller_pkg.sv
// Shared definitions for the attack controller: FSM encoding, grid geometry,
// result codes and the coordinate-to-map-bit mapping.
package attack_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    localparam logic [1:0] MODE_ATTACK = 2'b01;

    localparam int NUM_COLS  = 5;
    localparam int NUM_ROWS  = 7;
    localparam int NUM_CELLS = NUM_COLS * NUM_ROWS;

    localparam logic [2:0] MAX_COL = 3'd5;

    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_MISS   = 2'b01;
    localparam logic [1:0] RES_HIT    = 2'b10;
    localparam logic [1:0] RES_REPEAT = 2'b11;

    // Row is 3 bits wide, so only the lower bound needs checking for it.
    function automatic logic coord_valid(input logic [2:0] col, input logic [2:0] row);
        return (col >= 3'd1) && (col <= MAX_COL) && (row >= 3'd1);
    endfunction

    // Cell (row r, col c) lives at bit 34-((r-1)*5+(c-1)); row 1 col 1 is the MSB.
    function automatic logic [5:0] cell_index(input logic [2:0] col, input logic [2:0] row);
        logic [5:0] lin;
        lin = (6'(row) - 6'd1) * 6'd5 + (6'(col) - 6'd1);
        return 6'd34 - lin;
    endfunction

endpackage

// File: rtl/attack_controller_confirm_debouncer.sv
// Confirm button conditioning: 2-flop synchronizer, tick-sampled debouncer and
// a falling-edge detector producing a one-clock press pulse.
module confirm_debouncer #(
    parameter int DEB_TICKS = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic button_n_i,
    output logic press_o
);

    localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= button_n_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    // cnt_q counts consecutive differing samples already seen; the DEB_TICKS-th flips the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            if (sync2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEB_TICKS - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign press_o = level_prev_q & ~level_q;

endmodule

// File: rtl/attack_controller.sv
// Battleship attack phase controller: takes debounced confirm presses, marks
// attacked cells, scores hits/misses/repeats and flags the end of the game.
module attack_controller
    import attack_controller_pkg::*;
#(
    parameter int DEB_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 tick,
    input  logic                 button_confirmation,
    input  logic [1:0]           mode,
    input  logic [5:0]           at_in,
    input  logic [NUM_CELLS-1:0] m_po,
    output logic [NUM_CELLS-1:0] m_at,
    output logic [1:0]           result,
    output logic                 err_coord,
    output logic [5:0]           shot_count,
    output logic [5:0]           hit_count,
    output logic                 game_over,
    output logic [2:0]           state_dbg
);

    state_e               state_q, state_d;
    logic [NUM_CELLS-1:0] m_at_q, m_at_d;
    logic [1:0]           result_q, result_d;
    logic                 err_q, err_d;
    logic [5:0]           shot_q, shot_d;
    logic [5:0]           hit_q, hit_d;
    logic                 over_q, over_d;
    logic [5:0]           idx_q, idx_d;
    logic                 press;
    logic                 attacking;

    confirm_debouncer #(.DEB_TICKS(DEB_TICKS)) u_confirm (
        .clk_i      (clk),
        .rst_ni     (clr),
        .tick_i     (tick),
        .button_n_i (button_confirmation),
        .press_o    (press)
    );

    assign attacking = (mode == MODE_ATTACK);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            m_at_q   <= '0;
            result_q <= RES_NONE;
            err_q    <= 1'b0;
            shot_q   <= '0;
            hit_q    <= '0;
            over_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            m_at_q   <= m_at_d;
            result_q <= result_d;
            err_q    <= err_d;
            shot_q   <= shot_d;
            hit_q    <= hit_d;
            over_q   <= over_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        m_at_d   = m_at_q;
        result_d = result_q;
        err_d    = err_q;
        shot_d   = shot_q;
        hit_d    = hit_q;
        over_d   = over_q;
        idx_d    = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (attacking) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!attacking) begin
                    state_d = ST_IDLE;
                end else if (press) begin
                    if (coord_valid(at_in[5:3], at_in[2:0])) begin
                        idx_d   = cell_index(at_in[5:3], at_in[2:0]);
                        err_d   = 1'b0;
                        state_d = ST_CHECK;
                    end else begin
                        err_d    = 1'b1;
                        result_d = RES_NONE;
                    end
                end
            end
            // Leaving attack mode here abandons the shot before anything is written.
            ST_CHECK: begin
                if (!attacking) begin
                    state_d = ST_IDLE;
                end else begin
                    if (m_at_q[idx_q]) begin
                        result_d = RES_REPEAT;
                    end else begin
                        m_at_d[idx_q] = 1'b1;
                        shot_d        = shot_q + 6'd1;
                        if (m_po[idx_q]) begin
                            result_d = RES_HIT;
                            hit_d    = hit_q + 6'd1;
                        end else begin
                            result_d = RES_MISS;
                        end
                    end
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (!attacking) begin
                    state_d = ST_IDLE;
                end else if (((m_po & ~m_at_q) == '0) && (m_po != '0)) begin
                    over_d  = 1'b1;
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_at       = m_at_q;
    assign result     = result_q;
    assign err_coord  = err_q;
    assign shot_count = shot_q;
    assign hit_count  = hit_q;
    assign game_over  = over_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/attack_controller.md
ATTACK_CONTROLLER -- requirements
Module: attack_controller

Interface
REQ-001 Parameter DEB_TICKS, default 4, is the number of consecutive equal tick samples needed to accept a button level.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 clr  input  1  reset, asynchronous and active-low.
REQ-004 tick  input  1  single-cycle sample strobe from the frequency divider; gates debounce sampling only.
REQ-005 button_confirmation  input  1  raw push button, active-low (0 = pressed), asynchronous to clk.
REQ-006 mode  input  2  game status; 2'b01 = attack phase, any other value = not attacking.
REQ-007 at_in  input  6  attack coordinate; [5:3] column (valid 1..5), [2:0] row (valid 1..7).
REQ-008 m_po  input  35  ship map, 1 = ship; cell (row r, col c) at bit 34-((r-1)*5+(c-1)); must be stable while mode==2'b01.
REQ-009 m_at  output  35  attacked-cell map, same indexing as m_po.
REQ-010 result  output  2  last outcome: 00 none, 01 miss, 10 hit, 11 repeat.
REQ-011 err_coord  output  1  last accepted press had an invalid coordinate.
REQ-012 shot_count  output  6  count of distinct cells attacked.
REQ-013 hit_count  output  6  count of ship cells hit.
REQ-014 game_over  output  1  every ship cell has been hit.

Function
REQ-015 button_confirmation SHALL pass a 2-flop synchronizer, then a debouncer that changes its stable level only after DEB_TICKS consecutive tick samples at the new level.
REQ-016 A press event SHALL be a one-clk pulse on the debounced 1->0 transition; releases generate nothing.
REQ-017 FSM states: IDLE, WAIT, CHECK, UPDATE, OVER.
REQ-018 IDLE -> WAIT when mode==2'b01; WAIT/CHECK/UPDATE -> IDLE when mode!=2'b01, with the pending press discarded and no map/counter change.
REQ-019 WAIT + press + valid coordinate -> CHECK, clearing err_coord; WAIT + press + invalid coordinate (column 0,6,7 or row 0) -> stay WAIT, err_coord=1, result=00.
REQ-020 Coordinate SHALL be latched on the press cycle; later at_in changes SHALL not affect that attack.
REQ-021 CHECK (one cycle): cell already set in m_at -> result=11, no counter or map change; else set the m_at bit, shot_count+1, result=10 with hit_count+1 if the m_po bit is 1, otherwise result=01.
REQ-022 UPDATE (one cycle): game_over=1 and -> OVER if (m_po & ~m_at)==0 and m_po!=0; else -> WAIT.
REQ-023 Latency: press pulse at cycle N; CHECK at N+1; m_at, counters, result visible at N+2; game_over at N+3.
REQ-024 Presses arriving in CHECK or UPDATE SHALL be ignored.
REQ-025 OVER SHALL hold all outputs and ignore presses and mode until clr.
REQ-026 result and err_coord SHALL hold until the next accepted press.
REQ-027 Counters cannot exceed 35 (repeats not counted); no wrap logic is required, and their values are retained across IDLE.

Reset
REQ-028 clr low SHALL asynchronously force state IDLE, m_at=0, result=00, err_coord=0, shot_count=0, hit_count=0, game_over=0, synchronizer flops and debounced level to 1 (released), debounce counter to 0.
REQ-029 Reset asserted mid-debounce or mid-CHECK SHALL leave no partial update after release.

Structure
REQ-030 Shared package SHALL hold: state encoding, MODE_ATTACK=2'b01, grid constants (5 columns, 7 rows, 35 cells), result codes, coordinate-to-bit-index function.
REQ-031 Synchronizer, debouncer and edge detector SHALL be one sub-module, confirm_debouncer.

Verification
REQ-032 mode=01, m_po bit for (r1,c1) set, at_in=6'b001_001, one clean press -> at N+2: m_at[34]=1, result=10, hit_count=1, shot_count=1.
REQ-033 Same cell pressed again -> result=11, counters unchanged; then at_in=6'b010_001 (col2,row1) with no ship -> result=01, shot_count=2.
REQ-034 at_in=6'b110_011 press -> err_coord=1, m_at unchanged, state stays WAIT.
REQ-035 Button bounce of 1-tick glitches with DEB_TICKS=4 -> no press; level held 4 ticks -> exactly one press.
REQ-036 m_po with 2 ship cells, hit both -> game_over=1 one cycle after the second hit; further presses and mode=10 change nothing.
REQ-037 clr pulsed low while in CHECK -> all outputs zero immediately, state IDLE, no m_at bit set after release.
